pc_fetch_unit: RTL and testbench

//  Owns the program counter and drives instruction fetch for the 16-bit CPU. It is the consumer of
//  the PC-select mux output: it returns pc_next (PC+1) to the mux and accepts the selected target as
//  a redirect. Fetched words go to the IF/ID register interface. Interrupt entry to INT_VECTOR and

---
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Owns the program counter of the 16-bit CPU and drives instruction fetch.
//   It returns PC+1 to the PC-select mux and takes the mux's selection back
//   as a redirect. Fetched words are held in the IF/ID output register.
//   Interrupt entry (jump to INT_VECTOR, save epc) and return (eret) are
//   sequenced here.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_pc_sel      [15:0] redirect target from the PC-select mux
//   i_redirect    load i_pc_sel as the next PC (taken branch/jump)
//   i_stall       decode cannot accept; hold PC and IF outputs
//   i_int_req     level interrupt request
//   i_eret        return from interrupt, resume at epc
//   i_imem_ready  i_imem_data is valid this cycle for o_imem_addr
//   i_imem_data   [15:0] instruction word
//   o_imem_req    fetch request
//   o_imem_addr   [15:0] fetch address (= pc)
//   o_pc_next     [15:0] pc+1, wraps FFFF -> 0000
//   o_if_valid    o_if_instr/o_if_pc hold a valid instruction
//   o_if_instr    [15:0] fetched instruction
//   o_if_pc       [15:0] address of o_if_instr
//   o_epc         [15:0] saved resume PC
//   o_int_ack     one-cycle pulse on interrupt entry
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0005
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_pc_sel,
    input  logic        i_redirect,
    input  logic        i_stall,
    input  logic        i_int_req,
    input  logic        i_eret,
    input  logic        i_imem_ready,
    input  logic [15:0] i_imem_data,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    output logic [15:0] o_pc_next,
    output logic        o_if_valid,
    output logic [15:0] o_if_instr,
    output logic [15:0] o_if_pc,
    output logic [15:0] o_epc,
    output logic        o_int_ack
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_INTENT = 2'd2
    } state_t;

    // IF/ID output register bundle
    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
    } if_reg_t;

    state_t      r_state,    w_state_nxt;
    logic [15:0] r_pc,       w_pc_nxt;
    logic [15:0] r_epc,      w_epc_nxt;
    logic        r_int_mask, w_int_mask_nxt;
    if_reg_t     r_if,       w_if_nxt;

    logic [15:0] w_pc_inc;

    // 16-bit modulo increment: FFFF wraps to 0000 naturally
    assign w_pc_inc = r_pc + 16'd1;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_epc      <= 16'h0000;
            r_int_mask <= 1'b0;
            r_if       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_int_mask <= w_int_mask_nxt;
            r_if       <= w_if_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_int_mask_nxt = r_int_mask;
        w_if_nxt       = r_if;

        case (r_state)
            // One dead cycle out of reset; no control input is honoured.
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end

            // Vector already loaded on entry; just return to fetching.
            ST_INTENT: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                if (i_redirect) begin
                    // Wins over everything, including a pending interrupt:
                    // the level int_req is then taken next cycle with
                    // epc = the redirect target, so the branch survives.
                    w_pc_nxt       = i_pc_sel;
                    w_if_nxt.valid = 1'b0;
                end else if (i_eret) begin
                    w_pc_nxt       = r_epc;
                    w_int_mask_nxt = 1'b0;
                    w_if_nxt.valid = 1'b0;
                end else if (i_int_req && !r_int_mask) begin
                    w_epc_nxt      = r_pc;
                    w_pc_nxt       = INT_VECTOR;
                    w_int_mask_nxt = 1'b1;
                    w_if_nxt.valid = 1'b0;
                    w_state_nxt    = ST_INTENT;
                end else if (i_stall) begin
                    // Hold pc and the IF register; any response is dropped.
                end else if (i_imem_ready) begin
                    w_if_nxt.valid = 1'b1;
                    w_if_nxt.instr = i_imem_data;
                    w_if_nxt.pc    = r_pc;
                    w_pc_nxt       = w_pc_inc;
                end else begin
                    // Memory wait state: bubble into decode.
                    w_if_nxt.valid = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_imem_req  = (r_state == ST_FETCH) && !i_stall;
    assign o_imem_addr = r_pc;
    assign o_pc_next   = w_pc_inc;
    assign o_if_valid  = r_if.valid;
    assign o_if_instr  = r_if.instr;
    assign o_if_pc     = r_if.pc;
    assign o_epc       = r_epc;
    assign o_int_ack   = (r_state == ST_INTENT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. Instruction memory returns
//   addr ^ 16'hA5A5; ready is driven per step. Inputs change 1 time unit
//   after a rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_sel;
    logic        redirect, stall, int_req, eret, imem_ready;
    logic [15:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr, pc_next;
    logic        if_valid;
    logic [15:0] if_instr, if_pc, epc;
    logic        int_ack;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(16'h0000), .INT_VECTOR(16'h0005)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pc_sel     (pc_sel),
        .i_redirect   (redirect),
        .i_stall      (stall),
        .i_int_req    (int_req),
        .i_eret       (eret),
        .i_imem_ready (imem_ready),
        .i_imem_data  (imem_data),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .o_pc_next    (pc_next),
        .o_if_valid   (if_valid),
        .o_if_instr   (if_instr),
        .o_if_pc      (if_pc),
        .o_epc        (epc),
        .o_int_ack    (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ 16'hA5A5;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_sel = 16'h0; redirect = 1'b0; stall = 1'b0;
        int_req = 1'b0; eret = 1'b0; imem_ready = 1'b1;

        // ---- reset state ----
        #1;
        chk("rst_addr",   imem_addr, 16'h0000);
        chk("rst_req",    {15'b0, imem_req}, 16'h0);
        chk("rst_valid",  {15'b0, if_valid}, 16'h0);
        chk("rst_ack",    {15'b0, int_ack},  16'h0);
        chk("rst_epc",    epc,      16'h0000);
        chk("rst_ifpc",   if_pc,    16'h0000);
        chk("rst_instr",  if_instr, 16'h0000);
        chk("rst_pcnext", pc_next,  16'h0001);
        step(); step();
        rst_n = 1'b1;

        // ---- 1: boot then zero-wait stream ----
        chk("boot_req", {15'b0, imem_req}, 16'h0);
        step();                                  // edge 1: BOOT -> FETCH
        chk("e1_valid", {15'b0, if_valid}, 16'h0);
        chk("e1_req",   {15'b0, imem_req}, 16'h1);
        chk("e1_addr",  imem_addr, 16'h0000);
        step();                                  // edge 2: first instruction
        chk("e2_valid", {15'b0, if_valid}, 16'h1);
        chk("e2_ifpc",  if_pc,    16'h0000);
        chk("e2_instr", if_instr, 16'hA5A5);
        step();
        chk("e3_ifpc",  if_pc,    16'h0001);
        chk("e3_instr", if_instr, 16'hA5A4);
        step();
        chk("e4_ifpc",  if_pc,    16'h0002);
        chk("e4_addr",  imem_addr, 16'h0003);

        // ---- 2: two wait states at pc=0003 ----
        imem_ready = 1'b0;
        step();
        chk("w1_valid", {15'b0, if_valid}, 16'h0);
        chk("w1_addr",  imem_addr, 16'h0003);
        step();
        chk("w2_valid", {15'b0, if_valid}, 16'h0);
        chk("w2_addr",  imem_addr, 16'h0003);
        imem_ready = 1'b1;
        step();
        chk("w3_valid", {15'b0, if_valid}, 16'h1);
        chk("w3_ifpc",  if_pc, 16'h0003);
        step();
        chk("s0_ifpc",  if_pc, 16'h0004);
        chk("s0_addr",  imem_addr, 16'h0005);

        // ---- 3: stall for 3 cycles with if_pc=0004 ----
        stall = 1'b1;
        #1;
        chk("s0_req", {15'b0, imem_req}, 16'h0);
        step();
        chk("s1_ifpc",  if_pc,    16'h0004);
        chk("s1_instr", if_instr, 16'hA5A1);
        chk("s1_valid", {15'b0, if_valid}, 16'h1);
        chk("s1_addr",  imem_addr, 16'h0005);
        step();
        chk("s2_ifpc",  if_pc,    16'h0004);
        chk("s2_addr",  imem_addr, 16'h0005);
        chk("s2_req",   {15'b0, imem_req}, 16'h0);

        // ---- 4: redirect during the third stalled cycle ----
        redirect = 1'b1; pc_sel = 16'h0040;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("rd_valid", {15'b0, if_valid}, 16'h0);
        chk("rd_addr",  imem_addr, 16'h0040);
        step();
        chk("rd_ifpc",  if_pc,    16'h0040);
        chk("rd_instr", if_instr, 16'hA5E5);

        // ---- 5: interrupt at pc=0010, masking, eret ----
        redirect = 1'b1; pc_sel = 16'h0010;
        step();
        redirect = 1'b0;
        chk("i0_addr", imem_addr, 16'h0010);
        int_req = 1'b1;
        step();                                  // INTENT
        chk("i1_ack",   {15'b0, int_ack},  16'h1);
        chk("i1_epc",   epc,       16'h0010);
        chk("i1_addr",  imem_addr, 16'h0005);
        chk("i1_req",   {15'b0, imem_req}, 16'h0);
        chk("i1_valid", {15'b0, if_valid}, 16'h0);
        step();                                  // back in FETCH, masked
        chk("i2_ack",   {15'b0, int_ack},  16'h0);
        chk("i2_addr",  imem_addr, 16'h0005);
        step();                                  // int_req still high: ignored
        chk("i3_ack",   {15'b0, int_ack},  16'h0);
        chk("i3_ifpc",  if_pc, 16'h0005);
        chk("i3_addr",  imem_addr, 16'h0006);
        int_req = 1'b0; eret = 1'b1;
        step();
        eret = 1'b0;
        chk("er_addr",  imem_addr, 16'h0010);
        chk("er_valid", {15'b0, if_valid}, 16'h0);
        step();
        chk("er_ifpc",  if_pc, 16'h0010);
        chk("er_addr2", imem_addr, 16'h0011);

        // ---- 6: wrap at FFFF, then redirect+int_req together ----
        redirect = 1'b1; pc_sel = 16'hFFFF;
        step();
        redirect = 1'b0;
        chk("wr_addr",   imem_addr, 16'hFFFF);
        chk("wr_pcnext", pc_next,   16'h0000);
        step();
        chk("wr_ifpc",   if_pc,     16'hFFFF);
        chk("wr_instr",  if_instr,  16'h5A5A);
        chk("wr_addr2",  imem_addr, 16'h0000);
        redirect = 1'b1; pc_sel = 16'h0100; int_req = 1'b1;
        step();
        redirect = 1'b0;
        chk("ri_ack",   {15'b0, int_ack}, 16'h0);
        chk("ri_addr",  imem_addr, 16'h0100);
        step();
        chk("ri_ack2",  {15'b0, int_ack}, 16'h1);
        chk("ri_epc",   epc,       16'h0100);
        chk("ri_addr2", imem_addr, 16'h0005);
        int_req = 1'b0;
        step();
        chk("ri_ack3",  {15'b0, int_ack}, 16'h0);
        step();
        chk("ri_ifpc",  if_pc, 16'h0005);

        // ---- async reset mid-fetch ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   {15'b0, imem_req}, 16'h0);
        chk("ar_addr",  imem_addr, 16'h0000);
        chk("ar_valid", {15'b0, if_valid}, 16'h0);
        chk("ar_epc",   epc,       16'h0000);
        chk("ar_ifpc",  if_pc,     16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
